// File: rtl/team_06_sram_tap_engine_pkg.sv
// Shared types and helpers for the multi-tap SRAM delay-line engine.
package team_06_tap_pkg;

    localparam int         BUS_W   = 32;
    localparam logic [3:0] SEL_ALL = 4'b1111;

    typedef enum logic [3:0] {
        IDLE,
        WR_REQ,
        WR_WAIT_HI,
        WR_WAIT_LO,
        RD_SETUP,
        RD_REQ,
        RD_WAIT_HI,
        RD_WAIT_LO,
        DONE
    } state_t;

    // One sample per 32-bit word, so buffer index maps to a word-aligned byte address.
    function automatic logic [BUS_W-1:0] byte_addr(input logic [BUS_W-1:0] base,
                                                   input logic [BUS_W-1:0] index);
        return base + (index << 2);
    endfunction

endpackage

// File: rtl/team_06_bus_handshake.sv
// Single-word request pulse plus busy-high/busy-low tracking toward the wishbone manager.
module team_06_bus_handshake
    import team_06_tap_pkg::*;
(
    input  logic             hwclk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_write,
    input  logic [BUS_W-1:0] adr,
    input  logic [BUS_W-1:0] wdat,
    output logic             done,
    output logic [BUS_W-1:0] rdat,
    output logic [BUS_W-1:0] bus_dat_o,
    output logic [BUS_W-1:0] bus_adr_o,
    output logic [3:0]       bus_sel_o,
    output logic             bus_write_o,
    output logic             bus_read_o,
    input  logic [BUS_W-1:0] bus_dat_i,
    input  logic             bus_busy_i
);

    typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_WAIT_HI, HS_WAIT_LO} hs_phase_t;

    hs_phase_t phase, phase_n;

    always_comb begin
        phase_n = phase;
        case (phase)
            HS_IDLE:    if (start)       phase_n = HS_REQ;
            HS_REQ:                      phase_n = HS_WAIT_HI;
            HS_WAIT_HI: if (bus_busy_i)  phase_n = HS_WAIT_LO;
            HS_WAIT_LO: if (!bus_busy_i) phase_n = HS_IDLE;
            default:                     phase_n = HS_IDLE;
        endcase
    end

    // Request strobes are registered so they are high exactly during the caller's *_REQ state.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            phase       <= HS_IDLE;
            bus_write_o <= 1'b0;
            bus_read_o  <= 1'b0;
            bus_sel_o   <= '0;
            bus_adr_o   <= '0;
            bus_dat_o   <= '0;
        end else begin
            phase       <= phase_n;
            bus_write_o <= start & is_write;
            bus_read_o  <= start & ~is_write;
            bus_sel_o   <= start ? SEL_ALL : 4'b0000;
            if (start) begin
                bus_adr_o <= adr;
                bus_dat_o <= wdat;
            end
        end
    end

    assign done = (phase == HS_WAIT_LO) && !bus_busy_i;
    assign rdat = bus_dat_i;

endmodule

// File: rtl/team_06_sram_tap_engine.sv
// Circular-buffer delay line: write each sample to SRAM, then read NUM_TAPS delayed samples back.
module team_06_sram_tap_engine
    import team_06_tap_pkg::*;
#(
    parameter int               SAMPLE_W  = 8,
    parameter int               ADDR_W    = 12,
    parameter int               NUM_TAPS  = 2,
    parameter logic [BUS_W-1:0] BASE_ADDR = 32'h3300_0000
) (
    input  logic                         hwclk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [SAMPLE_W-1:0]          sample_in,
    input  logic                         sample_valid,
    input  logic [NUM_TAPS*ADDR_W-1:0]   tap_offset,
    output logic [NUM_TAPS*SAMPLE_W-1:0] tap_out,
    output logic                         taps_valid,
    output logic                         engine_busy,
    output logic                         overrun,
    output logic [BUS_W-1:0]             bus_dat_o,
    output logic [BUS_W-1:0]             bus_adr_o,
    output logic [3:0]                   bus_sel_o,
    output logic                         bus_write_o,
    output logic                         bus_read_o,
    input  logic [BUS_W-1:0]             bus_dat_i,
    input  logic                         bus_busy_i
);

    localparam int              KW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t                       state, state_n;
    logic [ADDR_W-1:0]            wr_ptr;
    logic [ADDR_W:0]              fill;
    logic [NUM_TAPS*ADDR_W-1:0]   offs_q;
    logic [NUM_TAPS*SAMPLE_W-1:0] res_q;
    logic [KW-1:0]                tap_k;

    logic             hs_start, hs_is_write, hs_done;
    logic [BUS_W-1:0] hs_adr, hs_wdat, hs_rdat;

    logic [ADDR_W-1:0] cur_off, rd_idx;
    logic              skip_tap, last_tap;

    assign cur_off     = offs_q[tap_k*ADDR_W +: ADDR_W];
    assign rd_idx      = wr_ptr - cur_off;
    assign skip_tap    = ({1'b0, cur_off} >= fill);
    assign last_tap    = (tap_k == KW'(NUM_TAPS - 1));
    assign engine_busy = (state != IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_n     = state;
        hs_start    = 1'b0;
        hs_is_write = 1'b0;
        hs_adr      = '0;
        hs_wdat     = '0;
        case (state)
            IDLE: begin
                if (enable && sample_valid) begin
                    state_n     = WR_REQ;
                    hs_start    = 1'b1;
                    hs_is_write = 1'b1;
                    hs_adr      = byte_addr(BASE_ADDR, BUS_W'(wr_ptr));
                    hs_wdat     = BUS_W'(sample_in);
                end
            end
            WR_REQ:     state_n = WR_WAIT_HI;
            WR_WAIT_HI: if (bus_busy_i) state_n = WR_WAIT_LO;
            WR_WAIT_LO: if (hs_done)    state_n = RD_SETUP;
            RD_SETUP: begin
                if (skip_tap) begin
                    state_n = last_tap ? DONE : RD_SETUP;
                end else begin
                    state_n  = RD_REQ;
                    hs_start = 1'b1;
                    hs_adr   = byte_addr(BASE_ADDR, BUS_W'(rd_idx));
                end
            end
            RD_REQ:     state_n = RD_WAIT_HI;
            RD_WAIT_HI: if (bus_busy_i) state_n = RD_WAIT_LO;
            RD_WAIT_LO: if (hs_done)    state_n = last_tap ? DONE : RD_SETUP;
            DONE:       state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge hwclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            wr_ptr     <= '0;
            fill       <= '0;
            offs_q     <= '0;
            res_q      <= '0;
            tap_k      <= '0;
            tap_out    <= '0;
            taps_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            taps_valid <= 1'b0;
            overrun    <= sample_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (!enable)           fill   <= '0;
                    else if (sample_valid) offs_q <= tap_offset;
                end
                WR_WAIT_LO: begin
                    if (hs_done) begin
                        fill  <= (fill == DEPTH) ? fill : fill + (ADDR_W+1)'(1);
                        tap_k <= '0;
                    end
                end
                RD_SETUP: begin
                    if (skip_tap) begin
                        res_q[tap_k*SAMPLE_W +: SAMPLE_W] <= '0;
                        tap_k <= tap_k + KW'(1);
                    end
                end
                RD_WAIT_LO: begin
                    if (hs_done) begin
                        res_q[tap_k*SAMPLE_W +: SAMPLE_W] <= hs_rdat[SAMPLE_W-1:0];
                        tap_k <= tap_k + KW'(1);
                    end
                end
                DONE: begin
                    tap_out    <= res_q;
                    taps_valid <= 1'b1;
                    wr_ptr     <= wr_ptr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Bus words wider than a sample carry zero padding that is deliberately ignored.
    if (SAMPLE_W < BUS_W) begin : g_pad
        logic rdat_pad_unused;
        assign rdat_pad_unused = ^hs_rdat[BUS_W-1:SAMPLE_W];
    end

    team_06_bus_handshake u_bus (
        .hwclk       (hwclk),
        .reset       (reset),
        .start       (hs_start),
        .is_write    (hs_is_write),
        .adr         (hs_adr),
        .wdat        (hs_wdat),
        .done        (hs_done),
        .rdat        (hs_rdat),
        .bus_dat_o   (bus_dat_o),
        .bus_adr_o   (bus_adr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_write_o (bus_write_o),
        .bus_read_o  (bus_read_o),
        .bus_dat_i   (bus_dat_i),
        .bus_busy_i  (bus_busy_i)
    );

endmodule

// File: tb/tb_team_06_sram_tap_engine.sv
// Directed bench with an SRAM/manager responder model and expected-result scoreboard queues.
module tb_team_06_sram_tap_engine;

    localparam int          SW   = 8;
    localparam int          AW   = 4;
    localparam int          NT   = 2;
    localparam logic [31:0] BASE = 32'h3300_0000;

    logic             hwclk;
    logic             reset;
    logic             enable;
    logic [SW-1:0]    sample_in;
    logic             sample_valid;
    logic [NT*AW-1:0] tap_offset;
    logic [NT*SW-1:0] tap_out;
    logic             taps_valid, engine_busy, overrun;
    logic [31:0]      bus_dat_o, bus_adr_o, bus_dat_i;
    logic [3:0]       bus_sel_o;
    logic             bus_write_o, bus_read_o, bus_busy_i;

    team_06_sram_tap_engine #(
        .SAMPLE_W (SW),
        .ADDR_W   (AW),
        .NUM_TAPS (NT),
        .BASE_ADDR(BASE)
    ) dut (
        .hwclk       (hwclk),
        .reset       (reset),
        .enable      (enable),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .tap_offset  (tap_offset),
        .tap_out     (tap_out),
        .taps_valid  (taps_valid),
        .engine_busy (engine_busy),
        .overrun     (overrun),
        .bus_dat_o   (bus_dat_o),
        .bus_adr_o   (bus_adr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_write_o (bus_write_o),
        .bus_read_o  (bus_read_o),
        .bus_dat_i   (bus_dat_i),
        .bus_busy_i  (bus_busy_i)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Scoreboard queues filled by the reference model when a sample is driven.
    logic [31:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];
    logic [31:0] rd_adr_q[$];
    logic [15:0] tap_q[$];

    logic [7:0]  ref_mem [16];
    logic [3:0]  ref_ptr = '0;
    int          ref_fill = 0;

    logic [7:0]  bus_mem [16];
    logic [31:0] last_wr_adr = '0;
    int          wr_count = 0;
    int          rd_count = 0;
    int          taps_seen = 0;
    int          hold_cycles = 1;
    logic        toggle_busy = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_sample(input logic [7:0] s, input logic [3:0] o1, input logic [3:0] o0);
        logic [3:0]  offs [2];
        logic [3:0]  idx;
        logic [15:0] exp_taps;
        offs[0] = o0;
        offs[1] = o1;
        wr_adr_q.push_back(BASE + 32'(ref_ptr) * 4);
        wr_dat_q.push_back({24'h0, s});
        ref_mem[ref_ptr] = s;
        if (ref_fill < 16) ref_fill++;
        exp_taps = '0;
        for (int k = 0; k < 2; k++) begin
            if (int'(offs[k]) < ref_fill) begin
                idx = ref_ptr - offs[k];
                rd_adr_q.push_back(BASE + 32'(idx) * 4);
                exp_taps[k*8 +: 8] = ref_mem[idx];
            end
        end
        tap_q.push_back(exp_taps);
        ref_ptr = ref_ptr + 4'd1;
    endtask

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (engine_busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_wait", {31'h0, engine_busy}, 32'h0);
    endtask

    task automatic wait_taps(input int target);
        int n = 0;
        while (taps_seen < target && n < 300) begin
            tick();
            n++;
        end
        check("taps_valid_count", taps_seen, target);
    endtask

    task automatic send_sample(input logic [7:0] s, input logic [3:0] o1, input logic [3:0] o0);
        wait_idle();
        model_sample(s, o1, o0);
        sample_in    = s;
        tap_offset   = {o1, o0};
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic send_and_wait(input logic [7:0] s, input logic [3:0] o1, input logic [3:0] o0);
        int target;
        target = taps_seen + 1;
        send_sample(s, o1, o0);
        wait_taps(target);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        ref_ptr  = '0;
        ref_fill = 0;
        reset    = 1'b0;
    endtask

    // Manager/SRAM responder: busy rises the cycle after a request and falls after hold_cycles.
    initial begin
        logic [31:0] off;
        logic        is_rd;
        bus_busy_i = 1'b0;
        bus_dat_i  = '0;
        forever begin
            tick();
            if (toggle_busy) begin
                bus_busy_i = ~bus_busy_i;
            end else if (!reset && (bus_write_o || bus_read_o)) begin
                off   = bus_adr_o - BASE;
                is_rd = bus_read_o;
                check("sel", {28'h0, bus_sel_o}, 32'hF);
                if (!is_rd) begin
                    wr_count++;
                    last_wr_adr = bus_adr_o;
                    if (wr_adr_q.size() == 0) begin
                        check("unexpected_write", {31'h0, bus_write_o}, 32'h0);
                    end else begin
                        check("wr_adr", bus_adr_o, wr_adr_q.pop_front());
                        check("wr_dat", bus_dat_o, wr_dat_q.pop_front());
                    end
                    bus_mem[off[5:2]] = bus_dat_o[7:0];
                end else begin
                    rd_count++;
                    if (rd_adr_q.size() == 0) check("unexpected_read", {31'h0, bus_read_o}, 32'h0);
                    else                      check("rd_adr", bus_adr_o, rd_adr_q.pop_front());
                end
                tick();
                bus_busy_i = 1'b1;
                for (int i = 0; i < hold_cycles; i++) begin
                    tick();
                    if (reset) break;
                end
                bus_busy_i = 1'b0;
                bus_dat_i  = is_rd ? {24'h0, bus_mem[off[5:2]]} : 32'h0;
            end else begin
                bus_busy_i = 1'b0;
            end
        end
    end

    // Output monitor: each taps_valid pulse consumes one expected tap vector.
    initial begin
        forever begin
            tick();
            if (taps_valid) begin
                taps_seen++;
                if (tap_q.size() == 0) check("unexpected_taps_valid", {31'h0, taps_valid}, 32'h0);
                else                   check("tap_out", {16'h0, tap_out}, {16'h0, tap_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, rd0, n;
        reset        = 1'b1;
        enable       = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        tap_offset   = '0;

        // Reset while bus_busy_i toggles.
        tick();
        tick();
        check("rst_tap_out", {16'h0, tap_out}, 32'h0);
        check("rst_taps_valid", {31'h0, taps_valid}, 32'h0);
        check("rst_engine_busy", {31'h0, engine_busy}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_bus_dat", bus_dat_o, 32'h0);
        check("rst_bus_adr", bus_adr_o, 32'h0);
        check("rst_bus_sel", {28'h0, bus_sel_o}, 32'h0);
        check("rst_bus_write", {31'h0, bus_write_o}, 32'h0);
        check("rst_bus_read", {31'h0, bus_read_o}, 32'h0);
        toggle_busy = 1'b0;
        tick();
        do_reset();
        enable = 1'b1;

        // First sample: one write, one read, far tap beyond fill.
        hold_cycles = 1;
        wr0 = wr_count;
        rd0 = rd_count;
        send_and_wait(8'h40, 4'd3, 4'd0);
        check("first_tap_out", {16'h0, tap_out}, 32'h0040);
        check("first_wr_adr", last_wr_adr, BASE);
        check("first_writes", wr_count - wr0, 1);
        check("first_reads", rd_count - rd0, 1);
        tick();
        tick();
        check("taps_valid_once", taps_seen, 1);

        // Buffer wrap with offsets {15, 0}.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            hold_cycles = 1 + (i % 3);
            send_and_wait(8'(i), 4'd15, 4'd0);
            if (i == 17) check("wrap_wr_adr", last_wr_adr, BASE);
        end
        check("wrap_tap_out", {16'h0, tap_out}, {16'h0, 8'd5, 8'd20});

        // Overrun: sample_valid during RD_WAIT_LO is dropped.
        hold_cycles = 3;
        wr0 = wr_count;
        send_sample(8'h33, 4'd15, 4'd0);
        n = 0;
        while (!bus_read_o && n < 50) begin
            tick();
            n++;
        end
        check("ovr_read_seen", {31'h0, bus_read_o}, 32'h1);
        tick();
        tick();
        sample_in    = 8'h99;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("overrun_pulse", {31'h0, overrun}, 32'h1);
        tick();
        check("overrun_clear", {31'h0, overrun}, 32'h0);
        wait_taps(taps_seen + 1);
        check("ovr_writes", wr_count - wr0, 1);
        hold_cycles = 1;
        send_and_wait(8'h34, 4'd15, 4'd0);
        check("ovr_next_wr_adr", last_wr_adr, BASE + 32'h14);

        // Reset in WR_WAIT_LO abandons the write.
        hold_cycles = 4;
        wait_idle();
        wr_adr_q.push_back(BASE + 32'(ref_ptr) * 4);
        wr_dat_q.push_back(32'h55);
        sample_in    = 8'h55;
        tap_offset   = {4'd2, 4'd0};
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        n = 0;
        while (!bus_write_o && n < 50) begin
            tick();
            n++;
        end
        check("abort_write_seen", {31'h0, bus_write_o}, 32'h1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_bus_write", {31'h0, bus_write_o}, 32'h0);
        check("abort_bus_read", {31'h0, bus_read_o}, 32'h0);
        check("abort_engine_busy", {31'h0, engine_busy}, 32'h0);
        ref_ptr  = '0;
        ref_fill = 0;
        tick();
        reset = 1'b0;
        tick();
        hold_cycles = 2;
        send_and_wait(8'h66, 4'd2, 4'd0);
        check("post_reset_wr_adr", last_wr_adr, BASE);
        check("post_reset_tap_out", {16'h0, tap_out}, 32'h0066);

        // Enable drop clears fill; ignored samples while disabled.
        for (int i = 0; i < 8; i++) begin
            hold_cycles = 1 + (i % 2);
            send_and_wait(8'hA0 + 8'(i), 4'd2, 4'd0);
        end
        wait_idle();
        enable   = 1'b0;
        ref_fill = 0;
        wr0 = wr_count;
        tick();
        sample_in    = 8'hEE;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("disabled_overrun", {31'h0, overrun}, 32'h0);
        check("disabled_busy", {31'h0, engine_busy}, 32'h0);
        tick();
        check("disabled_writes", wr_count - wr0, 0);
        enable = 1'b1;
        tick();
        rd0 = rd_count;
        send_and_wait(8'h7F, 4'd2, 4'd0);
        check("reenable_tap_out", {16'h0, tap_out}, 32'h007F);
        check("reenable_reads", rd_count - rd0, 1);

        tick();
        tick();
        check("tap_q_empty", tap_q.size(), 0);
        check("wr_q_empty", wr_adr_q.size(), 0);
        check("rd_q_empty", rd_adr_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/team_06_sram_tap_engine.md
Name: team_06_sram_tap_engine

Overview:
Parametrised multi-tap SRAM delay-line engine. It is the next generation of the single-offset sramRW path. Each accepted audio sample is written into a circular buffer in SRAM through the wishbone_manager CPU-side interface. NUM_TAPS delayed samples are then read back at independent runtime offsets and presented in parallel to the audio-effect stage for echo, reverb and chorus.

Parameters:
SAMPLE_W, 8, audio sample width in bits (≤ 32); zero-extended into a 32-bit bus word.
ADDR_W, 12, buffer index width; depth = 2^ADDR_W samples, one sample per 32-bit word.
NUM_TAPS, 2, number of independent read taps (≥ 1).
BASE_ADDR, 32'h3300_0000, byte address of buffer index 0.

Ports:
- hwclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  engine enable; samples are ignored when low.
- sample_in  in  SAMPLE_W  audio sample.
- sample_valid  in  1  one-cycle strobe; sample_in is valid on that cycle.
- tap_offset  in  NUM_TAPS*ADDR_W  flattened per-tap delay in samples; tap k occupies bits [k*ADDR_W +: ADDR_W].
- tap_out  out  NUM_TAPS*SAMPLE_W  flattened delayed samples, same packing.
- taps_valid  out  1  one-cycle pulse when tap_out has been updated.
- engine_busy  out  1  high in every state except IDLE.
- overrun  out  1  one-cycle pulse when a sample is dropped.
- bus_dat_o  out  32  write data to manager CPU_DAT_I.
- bus_adr_o  out  32  address to manager ADR_I.
- bus_sel_o  out  4  byte select; always 4'b1111 during a request.
- bus_write_o  out  1  one-cycle write request.
- bus_read_o  out  1  one-cycle read request.
- bus_dat_i  in  32  read data from manager CPU_DAT_O.
- bus_busy_i  in  1  manager BUSY_O.

Behaviour:
- Reset (sampled on hwclk):
  - all outputs are 0;
  - wr_ptr = 0, fill = 0;
  - state = IDLE.
  - Reset mid-transaction drops bus_write_o and bus_read_o on the next edge. The pending manager transaction is abandoned and its read data is discarded.
- States: IDLE, WR_REQ, WR_WAIT_HI, WR_WAIT_LO, RD_SETUP, RD_REQ, RD_WAIT_HI, RD_WAIT_LO, DONE.
- IDLE:
  - enable & sample_valid: latch sample_in, latch tap_offset snapshot, go to WR_REQ.
  - sample_valid while enable is low: ignored, no overrun.
- WR_REQ:
  - drive bus_write_o = 1 for one cycle;
  - bus_adr_o = BASE_ADDR + (wr_ptr << 2);
  - bus_dat_o = zero-extended sample.
- Request/wait handshake (both write and read):
  - *_WAIT_HI waits for bus_busy_i = 1.
  - *_WAIT_LO waits for bus_busy_i = 0.
  - The transaction completes on the cycle bus_busy_i is seen low.
  - Read data is captured from bus_dat_i on that same cycle.
  - No timeout.
- After write completes:
  - fill = min(fill + 1, 2^ADDR_W), saturating;
  - tap index k = 0;
  - go to RD_SETUP.
- RD_SETUP (tap k):
  - If offset_k ≥ fill: tap k result = 0, no bus read, advance k.
  - Otherwise go to RD_REQ with bus_adr_o = BASE_ADDR + (((wr_ptr - offset_k) mod 2^ADDR_W) << 2).
  - Offset 0 returns the sample just written.
- After the last tap: go to DONE.
- DONE:
  - update all tap_out lanes together;
  - pulse taps_valid;
  - wr_ptr = wr_ptr + 1 mod 2^ADDR_W (wraps 2^ADDR_W − 1 → 0);
  - return to IDLE.
- tap_out holds its value until the next DONE.
- Overrun: sample_valid while state ≠ IDLE pulses overrun for one cycle. The sample is dropped and wr_ptr and fill are unchanged.
- enable falling: the current sequence runs to DONE. fill is cleared to 0 on the first IDLE cycle with enable low. wr_ptr is retained.
- Minimum latency, sample_valid → taps_valid: 5 + 4·(taps read) cycles plus manager busy time.

Decomposition:
- Package team_06_tap_pkg holds:
  - the state enum;
  - BUS_W = 32;
  - SEL_ALL = 4'b1111;
  - a function computing the byte address from an index.
- Sub-module team_06_bus_handshake holds the request pulse and busy-high/busy-low tracking, shared by the write and read paths. Its interface is start, is_write, adr, wdat → done, rdat.

Test Plan:
- Reset with bus_busy_i toggling → every output 0 and state IDLE on the cycle after reset is sampled.
- Bench parameters ADDR_W=4, NUM_TAPS=2, offsets {tap1=3, tap0=0}; first sample 8'h40 → write at BASE_ADDR+0, one read at BASE_ADDR+0, tap_out = {8'h00, 8'h40}, taps_valid pulses once.
- Offsets {15, 0}; samples 1..20 → sample 17 is written at BASE_ADDR+0 (wrap); after sample 20, tap_out = {8'd5, 8'd20}.
- sample_valid asserted during RD_WAIT_LO → overrun pulse, no additional write, next accepted sample uses wr_ptr + 1.
- Reset asserted in WR_WAIT_LO → bus_write_o and bus_read_o are 0 next cycle; wr_ptr and fill are 0; the first post-reset sample is written at BASE_ADDR+0.
- After 8 samples, drop enable and re-raise it; sample 8'h7F with offsets {2, 0} → tap_out = {8'h00, 8'h7F} and exactly one bus read.
